// File: rtl/l1_cache_dm.sv
`default_nettype none
// ============================================================================
// Module   : l1_cache_dm
// Brief    : Direct-mapped, write-back, write-allocate L1 cache. 32-bit cpu
//            words in front, 256-bit line transfers to physical memory behind.
// Revision : 1.0 - initial release
// ============================================================================
module l1_cache_dm #(
    parameter int S_INDEX  = 3,
    parameter int S_OFFSET = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmem_read,
    input  logic         cmem_write,
    input  logic [3:0]   cmem_byte_enable,
    input  logic [31:0]  cmem_address,
    input  logic [31:0]  cmem_wdata,
    output logic [31:0]  cmem_rdata,
    output logic         cmem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);
    localparam int c_NUM_SETS = 2 ** S_INDEX;
    localparam int c_TAG_W    = 32 - S_INDEX - S_OFFSET;

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_WRITEBACK = 2'd1;
    localparam logic [1:0] c_ALLOCATE  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;

    logic               r_valid [c_NUM_SETS];
    logic               r_dirty [c_NUM_SETS];
    logic [c_TAG_W-1:0] r_tag   [c_NUM_SETS];
    logic [255:0]       r_data  [c_NUM_SETS];

    logic [c_TAG_W-1:0] r_miss_tag;
    logic [S_INDEX-1:0] r_miss_index;

    logic               w_request;
    logic               w_hit;
    logic               w_miss;
    logic               w_fill;
    logic               w_write_hit;
    logic [c_TAG_W-1:0] w_tag;
    logic [S_INDEX-1:0] w_index;
    logic [2:0]         w_word;
    logic [31:0]        w_word_data;
    logic [31:0]        w_merged;
    logic               w_unused;

    assign w_request   = cmem_read | cmem_write;
    assign w_tag       = cmem_address[31:S_OFFSET+S_INDEX];
    assign w_index     = cmem_address[S_OFFSET+S_INDEX-1:S_OFFSET];
    assign w_word      = cmem_address[4:2];
    assign w_unused    = ^cmem_address[1:0];
    assign w_word_data = r_data[w_index][{w_word, 5'b0} +: 32];

    // Hits are only recognised in IDLE; a refill re-evaluates the request there.
    assign w_hit       = (r_state == c_IDLE) & w_request & r_valid[w_index] &
                         (r_tag[w_index] == w_tag);
    assign w_miss      = (r_state == c_IDLE) & w_request & ~w_hit;
    assign w_fill      = (r_state == c_ALLOCATE) & pmem_resp;
    assign w_write_hit = w_hit & cmem_write;

    assign cmem_resp   = w_hit;
    assign cmem_rdata  = w_word_data;

    always_comb begin
        w_merged = w_word_data;
        for (int i = 0; i < 4; i++) begin
            if (cmem_byte_enable[i]) begin
                w_merged[8*i +: 8] = cmem_wdata[8*i +: 8];
            end
        end
    end

    // The victim's address comes from the stored tag, the refill's from the latch.
    assign pmem_address = {(r_state == c_WRITEBACK) ? r_tag[r_miss_index] : r_miss_tag,
                           r_miss_index, {S_OFFSET{1'b0}}};
    assign pmem_wdata   = r_data[r_miss_index];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_miss) begin
                    w_next_state = (r_valid[w_index] & r_dirty[w_index]) ? c_WRITEBACK
                                                                         : c_ALLOCATE;
                end
            end
            c_WRITEBACK: begin
                pmem_write = 1'b1;
                if (pmem_resp) begin
                    w_next_state = c_ALLOCATE;
                end
            end
            c_ALLOCATE: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_miss) begin
            r_miss_tag   <= w_tag;
            r_miss_index <= w_index;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_NUM_SETS; i++) begin
                r_valid[i] <= 1'b0;
                r_dirty[i] <= 1'b0;
            end
        end else if (w_fill) begin
            r_valid[r_miss_index] <= 1'b1;
            r_dirty[r_miss_index] <= 1'b0;
        end else if (w_write_hit) begin
            r_dirty[w_index] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; validity alone guards them.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_data[r_miss_index] <= pmem_rdata;
            r_tag[r_miss_index]  <= r_miss_tag;
        end else if (w_write_hit) begin
            r_data[w_index][{w_word, 5'b0} +: 32] <= w_merged;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_l1_cache_dm.sv
`default_nettype none
// ============================================================================
// Module   : tb_l1_cache_dm
// Brief    : Self-checking bench for l1_cache_dm: directed vector table,
//            reset corner sequence and randomized accesses against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l1_cache_dm;
    logic         clk = 1'b0;
    logic         reset;
    logic         cmem_read, cmem_write;
    logic [3:0]   cmem_byte_enable;
    logic [31:0]  cmem_address, cmem_wdata, cmem_rdata;
    logic         cmem_resp;
    logic         pmem_read, pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata, pmem_rdata;
    logic         pmem_resp;

    l1_cache_dm dut (
        .clk(clk), .reset(reset),
        .cmem_read(cmem_read), .cmem_write(cmem_write),
        .cmem_byte_enable(cmem_byte_enable), .cmem_address(cmem_address),
        .cmem_wdata(cmem_wdata), .cmem_rdata(cmem_rdata), .cmem_resp(cmem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct { bit wr; logic [31:0] addr; logic [255:0] data; } xfer_t;
    xfer_t log_q[$];

    logic [255:0] mem [logic [31:0]];
    int  tb_lat = 3;
    bit  tb_hold = 1'b0;
    int  inject_req = 0;
    int  inject_done = 0;
    int  resp_cnt = 0;

    // Cache model: per-set state plus the backing memory image.
    bit           m_valid [8];
    bit           m_dirty [8];
    logic [23:0]  m_tag   [8];
    logic [255:0] m_line  [8];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] get_line(input logic [31:0] la);
        logic [255:0] l;
        if (mem.exists(la)) return mem[la];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = {la[31:5], 3'(w), 2'b00} ^ 32'h5A5A_5A5A;
        return l;
    endfunction

    // Memory responder: answers each transfer tb_lat cycles after it appears.
    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            pmem_resp = 1'b0;
            if (inject_done != inject_req) begin
                pmem_resp = 1'b1;
                inject_done++;
            end else if ((pmem_read || pmem_write) && !tb_hold) begin
                resp_cnt++;
                if (resp_cnt >= tb_lat) begin
                    resp_cnt   = 0;
                    pmem_resp  = 1'b1;
                    pmem_rdata = get_line(pmem_address);
                    log_q.push_back('{pmem_write, pmem_address, pmem_wdata});
                end
            end else if (!(pmem_read || pmem_write)) begin
                resp_cnt = 0;
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endtask

    task automatic model_step(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] be, output logic [31:0] e_rdata,
                              output bit e_wb, output logic [31:0] e_wb_addr,
                              output logic [255:0] e_wb_line, output bit e_fill,
                              output logic [31:0] e_fill_addr);
        int idx = int'(a[7:5]);
        int w   = int'(a[4:2]);
        e_wb = 1'b0; e_fill = 1'b0; e_wb_addr = '0; e_wb_line = '0; e_fill_addr = '0;
        if (!(m_valid[idx] && m_tag[idx] == a[31:8])) begin
            if (m_valid[idx] && m_dirty[idx]) begin
                e_wb      = 1'b1;
                e_wb_addr = {m_tag[idx], a[7:5], 5'b0};
                e_wb_line = m_line[idx];
                mem[e_wb_addr] = m_line[idx];
            end
            e_fill      = 1'b1;
            e_fill_addr = {a[31:5], 5'b0};
            m_line[idx] = get_line(e_fill_addr);
            m_tag[idx]  = a[31:8];
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
        end
        e_rdata = m_line[idx][w*32 +: 32];
        if (wr) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) m_line[idx][w*32 + b*8 +: 8] = wd[b*8 +: 8];
            m_dirty[idx] = 1'b1;
        end
    endtask

    // Called just after a rising edge; returns just after the edge that took cmem_resp.
    task automatic cpu_access(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] wd, input logic [3:0] be,
                              output logic [31:0] rdata, output int cyc, output bit ok);
        log_q.delete();
        cmem_read = rd; cmem_write = wr; cmem_address = a;
        cmem_wdata = wd; cmem_byte_enable = be;
        ok = 1'b0; cyc = -1; rdata = '0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            chk("pmem_excl", {255'b0, pmem_read & pmem_write}, '0);
            if (cmem_resp) begin
                rdata = cmem_rdata; cyc = k; ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        cmem_read = 1'b0; cmem_write = 1'b0;
    endtask

    task automatic run_and_check(input logic rd, input logic wr, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [3:0] be,
                                 output logic [31:0] rdata);
        logic [31:0] e_rdata, e_wb_addr, e_fill_addr;
        logic [255:0] e_wb_line;
        bit e_wb, e_fill, ok;
        int cyc, exp_cyc, n, k;
        model_step(wr, a, wd, be, e_rdata, e_wb, e_wb_addr, e_wb_line, e_fill, e_fill_addr);
        exp_cyc = e_fill ? (e_wb ? 2*tb_lat + 1 : tb_lat + 1) : 0;
        cpu_access(rd, wr, a, wd, be, rdata, cyc, ok);
        chk($sformatf("resp_seen@%0h", a), {255'b0, ok}, 256'd1);
        chk($sformatf("latency@%0h", a), 256'(cyc), 256'(exp_cyc));
        if (rd && !wr) chk($sformatf("rdata@%0h", a), 256'(rdata), 256'(e_rdata));
        n = int'(e_wb) + int'(e_fill);
        chk($sformatf("xfer_count@%0h", a), 256'(log_q.size()), 256'(n));
        if (log_q.size() == n) begin
            k = 0;
            if (e_wb) begin
                chk("wb_dir", {255'b0, log_q[0].wr}, 256'd1);
                chk("wb_addr", 256'(log_q[0].addr), 256'(e_wb_addr));
                chk("wb_line", log_q[0].data, e_wb_line);
                k = 1;
            end
            if (e_fill) begin
                chk("fill_dir", {255'b0, log_q[k].wr}, '0);
                chk("fill_addr", 256'(log_q[k].addr), 256'(e_fill_addr));
            end
        end
    endtask

    typedef struct {
        logic rd; logic wr; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be;
        bit chk_rd; logic [31:0] exp_rdata; bit exp_fill; bit exp_wb;
        logic [31:0] exp_wb_addr; logic [31:0] exp_wb_word1;
    } vec_t;

    vec_t vecs[12];
    logic [255:0] line0;
    logic [31:0]  rdata;
    logic [23:0]  tags[4];

    initial begin
        vecs[0]  = '{1, 0, 32'h1004, 32'h0, 4'h0, 1, 32'hDEADBEEF, 1, 0, 32'h0, 32'h0};
        vecs[1]  = '{1, 0, 32'h1000, 32'h0, 4'h0, 1, 32'hC0DE0000, 0, 0, 32'h0, 32'h0};
        vecs[2]  = '{1, 0, 32'h1008, 32'h0, 4'h0, 1, 32'hC0DE0002, 0, 0, 32'h0, 32'h0};
        vecs[3]  = '{1, 0, 32'h101C, 32'h0, 4'h0, 1, 32'hC0DE0007, 0, 0, 32'h0, 32'h0};
        vecs[4]  = '{0, 1, 32'h1004, 32'h11223344, 4'hF, 0, 32'h0, 0, 0, 32'h0, 32'h0};
        vecs[5]  = '{0, 1, 32'h1004, 32'hAABBCCDD, 4'b0101, 0, 32'h0, 0, 0, 32'h0, 32'h0};
        vecs[6]  = '{1, 0, 32'h1004, 32'h0, 4'h0, 1, 32'h11BB33DD, 0, 0, 32'h0, 32'h0};
        vecs[7]  = '{1, 0, 32'h2004, 32'h0, 4'h0, 1, 32'h5A5A7A5E, 1, 1, 32'h1000, 32'h11BB33DD};
        vecs[8]  = '{1, 0, 32'h1004, 32'h0, 4'h0, 1, 32'h11BB33DD, 1, 0, 32'h0, 32'h0};
        vecs[9]  = '{1, 1, 32'h1008, 32'h01020304, 4'hF, 0, 32'h0, 0, 0, 32'h0, 32'h0};
        vecs[10] = '{1, 0, 32'h1008, 32'h0, 4'h0, 1, 32'h01020304, 0, 0, 32'h0, 32'h0};
        vecs[11] = '{1, 0, 32'h2000, 32'h0, 4'h0, 1, 32'h5A5A7A5A, 1, 1, 32'h1000, 32'h11BB33DD};
        tags = '{24'h000040, 24'h0000A1, 24'h00137F, 24'h00FFFF};

        for (int w = 0; w < 8; w++) line0[w*32 +: 32] = 32'hC0DE0000 + w;
        line0[63:32] = 32'hDEADBEEF;
        mem[32'h1000] = line0;

        cmem_read = 0; cmem_write = 0; cmem_byte_enable = 0;
        cmem_address = 0; cmem_wdata = 0;
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        chk("reset_cmem_resp", {255'b0, cmem_resp}, '0);
        chk("reset_pmem_read", {255'b0, pmem_read}, '0);
        chk("reset_pmem_write", {255'b0, pmem_write}, '0);
        @(posedge clk); #1;
        reset = 1'b0;

        tb_lat = 3;
        for (int i = 0; i < 12; i++) begin
            run_and_check(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, rdata);
            if (vecs[i].chk_rd) chk($sformatf("vec%0d_rdata", i), 256'(rdata), 256'(vecs[i].exp_rdata));
            chk($sformatf("vec%0d_xfers", i), 256'(log_q.size()),
                256'(int'(vecs[i].exp_fill) + int'(vecs[i].exp_wb)));
            if (vecs[i].exp_wb && log_q.size() > 0) begin
                chk($sformatf("vec%0d_wb_addr", i), 256'(log_q[0].addr), 256'(vecs[i].exp_wb_addr));
                chk($sformatf("vec%0d_wb_word1", i), 256'(log_q[0].data[63:32]),
                    256'(vecs[i].exp_wb_word1));
            end
            if (vecs[i].exp_fill && log_q.size() > 0)
                chk($sformatf("vec%0d_fill_addr", i), 256'(log_q[log_q.size()-1].addr),
                    256'({vecs[i].addr[31:5], 5'b0}));
        end

        // Reset in the middle of a refill, then a stray memory response in IDLE.
        tb_hold = 1'b1;
        cmem_read = 1'b1; cmem_address = 32'h3004;
        repeat (3) @(negedge clk);
        chk("midalloc_pmem_read", {255'b0, pmem_read}, 256'd1);
        chk("midalloc_addr", 256'(pmem_address), 256'h3000);
        reset = 1'b1; cmem_read = 1'b0;
        @(negedge clk);
        chk("abort_pmem_read", {255'b0, pmem_read}, '0);
        chk("abort_pmem_write", {255'b0, pmem_write}, '0);
        chk("abort_cmem_resp", {255'b0, cmem_resp}, '0);
        reset = 1'b0;
        inject_req++;
        repeat (3) begin
            @(negedge clk);
            chk("late_resp_ignored", {254'b0, pmem_read, pmem_write}, '0);
        end
        tb_hold = 1'b0;
        model_reset();
        @(posedge clk); #1;
        run_and_check(1'b1, 1'b0, 32'h1004, 32'h0, 4'h0, rdata);
        chk("post_reset_miss_xfers", 256'(log_q.size()), 256'd1);
        chk("post_reset_rdata", 256'(rdata), 256'h11BB33DD);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            int op;
            tb_lat = $urandom_range(1, 4);
            op = $urandom_range(0, 3);
            a = {tags[$urandom_range(0, 3)], 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            run_and_check(op != 2, op >= 2, a, $urandom, 4'($urandom_range(0, 15)), rdata);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
